// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, stop-bit check and
// a one-entry valid/ready output register with framing-error and overrun pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_sig,
  output logic [DATA_WIDTH-1:0] data_to_xbar,
  output logic                  valid_to_xbar,
  input  logic                  ready_from_xbar,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;
  localparam int BIT_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_sync1;
  logic                  r_rx_s;
  logic [CNT_W-1:0]      r_clk_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  r_overrun;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [BIT_W-1:0]      w_bit_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_valid_nxt;
  logic                  w_ferr_nxt;
  logic                  w_ovr_nxt;
  logic                  w_deliver;
  logic                  w_cnt_zero;

  assign w_cnt_zero = (r_clk_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync1     <= rx_sig;
      r_rx_s      <= r_sync1;
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_cnt_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_err <= w_ferr_nxt;
      r_overrun   <= w_ovr_nxt;
    end
  end

  // Bit-timing FSM: every sample is taken when the down-counter reaches zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_clk_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CNT_HALF;
        end
      end
      S_START: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_clk_cnt - CNT_W'(1);
        end else if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_cnt_nxt   = CNT_FULL;
        end
      end
      S_DATA: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_clk_cnt - CNT_W'(1);
        end else begin
          w_shift_nxt[r_bit_cnt] = r_rx_s;
          w_cnt_nxt              = CNT_FULL;
          if (r_bit_cnt == BIT_LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit_cnt + BIT_W'(1);
          end
        end
      end
      S_STOP: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_clk_cnt - CNT_W'(1);
        end else if (r_rx_s) begin
          w_deliver   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_ferr_nxt  = 1'b1;
          w_state_nxt = S_BREAK;
        end
      end
      S_BREAK: begin
        // A held-low line must return high before a new start is accepted.
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_ovr_nxt   = 1'b0;
    if (w_deliver) begin
      if (!r_valid || ready_from_xbar) begin
        w_data_nxt  = r_shift;
        w_valid_nxt = 1'b1;
      end else begin
        w_ovr_nxt = 1'b1;
      end
    end else if (r_valid && ready_from_xbar) begin
      w_valid_nxt = 1'b0;
    end
  end

  assign data_to_xbar  = r_data;
  assign valid_to_xbar = r_valid;
  assign frame_err     = r_frame_err;
  assign overrun       = r_overrun;

endmodule
